mips_bus_arbiter: RTL and testbench
===================================

MIPS_BUS_ARBITER -- requirements
Module: mips_bus_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 0: max waitrequest cycles per bus access; 0 disables the timeout.
REQ-002 Parameter DATA_FIRST, default 1: 1 = data port wins simultaneous requests; 0 = fetch port wins.
REQ-003 clk  input  1  clock; all logic on the rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 f_req  input  1  fetch request; held with f_addr until f_ready.
REQ-006 f_addr  input  32  fetch byte address.
REQ-007 f_ready  output  1  one-cycle fetch completion pulse.
REQ-008 f_rdata  output  32  fetched word; valid while f_ready.
REQ-009 f_err  output  1  fetch fault (misaligned or timeout); valid while f_ready.
REQ-010 d_req  input  1  data request; held with all d_* inputs until d_ready.
REQ-011 d_we  input  1  1 = store, 0 = load.
REQ-012 d_size  input  2  0 = byte, 1 = half, 2 = word; 3 = misaligned fault.
REQ-013 d_signed  input  1  load sign-extends when 1, zero-extends when 0.
REQ-014 d_addr  input  32  data byte address.
REQ-015 d_wdata  input  32  store data, right-justified.
REQ-016 d_ready  output  1  one-cycle data completion pulse.
REQ-017 d_rdata  output  32  extended load result; valid while d_ready.
REQ-018 d_err  output  1  data fault; valid while d_ready.
REQ-019 address, write, read, writedata[31:0], byteenable[3:0]  output  Avalon master; all registered.
REQ-020 readdata[31:0], waitrequest  input  Avalon slave response.
REQ-021 busy  output  1  high in any state other than IDLE.

Function
REQ-022 FSM states: IDLE, ACCESS, RESP.
REQ-023 IDLE: with no request, stay IDLE; with a request, grant per DATA_FIRST and latch port, address, size, signed, we and wdata.
REQ-024 Misaligned grant (half with addr[0]=1, or word with addr[1:0]!=0): go to RESP with err=1; no bus cycle issued.
REQ-025 Aligned grant: go to ACCESS; drive address={addr[31:2],2'b00}, read=!we, write=we.
REQ-026 Fetch accesses are always word-size loads.
REQ-027 byteenable: byte = 4'b0001<<addr[1:0]; half = 4'b0011<<addr[1:0]; word = 4'b1111.
REQ-028 writedata: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
REQ-029 Address, control and data stay stable throughout ACCESS while waitrequest=1.
REQ-030 ACCESS with waitrequest=0: capture readdata (loads); deassert read/write; go to RESP.
REQ-031 Load extraction: select the addressed lane, then sign- or zero-extend to 32 bits per d_signed.
REQ-032 Timeout (TIMEOUT>0): count ACCESS cycles with waitrequest=1; on reaching TIMEOUT, deassert read/write and go to RESP with err=1.
REQ-033 RESP: pulse ready, with rdata and err, on the granted port for exactly one cycle; then go to IDLE.
REQ-034 Latency: aligned request seen in IDLE at edge N with zero wait gives ready high in cycle N+2; each wait cycle adds one.
REQ-035 The ungranted port's request stays pending and is granted on the next IDLE cycle; no back-to-back starvation, because RESP always returns to IDLE.
REQ-036 ready, rdata and err are zero whenever ready is low.

Reset
REQ-037 reset forces IDLE and sets every output to 0 (byteenable 4'b0000) at the next edge, including mid-ACCESS, where the bus cycle is abandoned.
REQ-038 reset clears the timeout counter and all latched request fields.

Structure
REQ-039 Shared package mips_pkg holds the size enum (SIZE_BYTE, SIZE_HALF, SIZE_WORD) and the arbiter state enum.
REQ-040 Sub-module mips_lane_align: combinational; generates byteenable, writedata replication and load extraction/extension from addr[1:0], size and signed.

Verification
REQ-041 d_req lw, d_addr=0x1000, waitrequest=0, readdata=0xDEADBEEF -> address 0x1000, byteenable 1111, d_ready at +2 with d_rdata 0xDEADBEEF.
REQ-042 d_req sb, d_addr=0x1003, d_wdata=0xAB, 3 wait cycles -> byteenable 1000, writedata 0xABABABAB held 4 cycles; d_ready at +5.
REQ-043 lh at 0x1002, readdata=0x8001_0000, signed=1 -> d_rdata 0xFFFF8001; same load with signed=0 -> 0x00008001.
REQ-044 f_req and d_req same cycle, DATA_FIRST=1 -> data access first, then fetch; f_ready follows d_ready by 3 cycles.
REQ-045 lw at 0x1002 -> no read asserted, d_ready+d_err at +1; TIMEOUT=4 with waitrequest stuck high -> read drops, err pulse after 4 wait cycles.
REQ-046 reset asserted during ACCESS with waitrequest high -> read=0, busy=0, no ready pulse next cycle.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types for the MIPS bus arbiter: access-size encoding, arbiter state,
// and the alignment rule used to reject a request before it reaches the bus.
package mips_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_e;

    // Size code 3 has no legal encoding and is reported as a fault.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
        return (size == 2'd3) ||
               (size == SIZE_HALF && lo[0]) ||
               (size == SIZE_WORD && lo != 2'b00);
    endfunction

endpackage

// File: rtl/mips_bus_arbiter_if.sv
// CPU fetch/data ports plus the Avalon master bus, bundled for the arbiter.
// master = arbiter side, slave = CPU + memory side.
interface mips_bus_arbiter_if;
    logic        f_req;
    logic [31:0] f_addr;
    logic        f_ready;
    logic [31:0] f_rdata;
    logic        f_err;

    logic        d_req;
    logic        d_we;
    logic [1:0]  d_size;
    logic        d_signed;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic        d_err;

    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;
    logic        waitrequest;
    logic        busy;

    modport master (
        input  f_req, f_addr, d_req, d_we, d_size, d_signed, d_addr, d_wdata,
        input  readdata, waitrequest,
        output f_ready, f_rdata, f_err, d_ready, d_rdata, d_err,
        output address, read, write, writedata, byteenable, busy
    );

    modport slave (
        output f_req, f_addr, d_req, d_we, d_size, d_signed, d_addr, d_wdata,
        output readdata, waitrequest,
        input  f_ready, f_rdata, f_err, d_ready, d_rdata, d_err,
        input  address, read, write, writedata, byteenable, busy
    );
endinterface

// File: rtl/mips_lane_align.sv
// Byte-lane steering for a 32-bit bus: byteenable and store replication on the
// way out, lane select and sign/zero extension on the way back.
module mips_lane_align
    import mips_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_signed,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  byteenable,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);
    logic [31:0] shifted;

    always_comb begin
        shifted    = rdata >> {addr_lo, 3'b000};
        byteenable = 4'b1111;
        wdata_rep  = wdata;
        rdata_ext  = shifted;
        case (size)
            SIZE_BYTE: begin
                byteenable = 4'b0001 << addr_lo;
                wdata_rep  = {4{wdata[7:0]}};
                rdata_ext  = {{24{is_signed & shifted[7]}}, shifted[7:0]};
            end
            SIZE_HALF: begin
                byteenable = 4'b0011 << addr_lo;
                wdata_rep  = {2{wdata[15:0]}};
                rdata_ext  = {{16{is_signed & shifted[15]}}, shifted[15:0]};
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/mips_bus_arbiter.sv
// Arbitrates the CPU fetch and data ports onto one Avalon master; one access
// in flight, every access returns through IDLE so neither port starves.
module mips_bus_arbiter
    import mips_pkg::*;
#(
    parameter int TIMEOUT    = 0,
    parameter bit DATA_FIRST = 1'b1
) (
    input logic                 clk,
    input logic                 reset,
    mips_bus_arbiter_if.master  bus
);
    localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

    arb_state_e  state_q, state_d;
    logic        port_q, port_d;          // 1 = data port owns the access
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic [1:0]  size_q, size_d;
    logic        signed_q, signed_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic [31:0] address_q, address_d, writedata_q, writedata_d;
    logic [3:0]  byteenable_q, byteenable_d;
    logic        read_q, read_d, write_q, write_d;
    logic        f_ready_q, f_ready_d, f_err_q, f_err_d;
    logic        d_ready_q, d_ready_d, d_err_q, d_err_d;
    logic [31:0] f_rdata_q, f_rdata_d, d_rdata_q, d_rdata_d;

    logic        take_d, req_we, req_signed, is_idle;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic [3:0]  la_be;
    logic [31:0] la_wdata, la_rdata;
    logic        rsp_fire, rsp_err;
    logic [31:0] rsp_data;

    always_comb begin
        take_d     = bus.d_req && (DATA_FIRST || !bus.f_req);
        req_addr   = take_d ? bus.d_addr : bus.f_addr;
        req_size   = take_d ? bus.d_size : SIZE_WORD;
        req_signed = take_d && bus.d_signed;
        req_we     = take_d && bus.d_we;
        req_wdata  = take_d ? bus.d_wdata : 32'h0;
        is_idle    = (state_q == ST_IDLE);
    end

    // One aligner serves both directions: incoming request while IDLE,
    // latched request fields while the access completes.
    mips_lane_align u_align (
        .addr_lo    (is_idle ? req_addr[1:0] : addr_lo_q),
        .size       (is_idle ? req_size : size_q),
        .is_signed  (is_idle ? req_signed : signed_q),
        .wdata      (req_wdata),
        .rdata      (bus.readdata),
        .byteenable (la_be),
        .wdata_rep  (la_wdata),
        .rdata_ext  (la_rdata)
    );

    always_comb begin
        state_d      = state_q;
        port_d       = port_q;
        addr_lo_d    = addr_lo_q;
        size_d       = size_q;
        signed_d     = signed_q;
        wait_cnt_d   = wait_cnt_q;
        address_d    = address_q;
        writedata_d  = writedata_q;
        byteenable_d = byteenable_q;
        read_d       = read_q;
        write_d      = write_q;
        rsp_fire     = 1'b0;
        rsp_err      = 1'b0;
        rsp_data     = 32'h0;
        case (state_q)
            ST_IDLE: if (bus.f_req || bus.d_req) begin
                port_d     = take_d;
                addr_lo_d  = req_addr[1:0];
                size_d     = req_size;
                signed_d   = req_signed;
                wait_cnt_d = 16'h0;
                if (misaligned(req_size, req_addr[1:0])) begin
                    rsp_fire = 1'b1;
                    rsp_err  = 1'b1;
                    state_d  = ST_RESP;
                end else begin
                    address_d    = {req_addr[31:2], 2'b00};
                    byteenable_d = la_be;
                    writedata_d  = la_wdata;
                    read_d       = !req_we;
                    write_d      = req_we;
                    state_d      = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (!bus.waitrequest) begin
                    read_d   = 1'b0;
                    write_d  = 1'b0;
                    rsp_fire = 1'b1;
                    rsp_data = read_q ? la_rdata : 32'h0;
                    state_d  = ST_RESP;
                end else if (TIMEOUT > 0 && wait_cnt_q + 16'd1 == TIMEOUT_CNT) begin
                    read_d   = 1'b0;
                    write_d  = 1'b0;
                    rsp_fire = 1'b1;
                    rsp_err  = 1'b1;
                    state_d  = ST_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        f_ready_d = rsp_fire && !port_d;
        f_err_d   = rsp_fire && !port_d && rsp_err;
        f_rdata_d = (rsp_fire && !port_d) ? rsp_data : 32'h0;
        d_ready_d = rsp_fire && port_d;
        d_err_d   = rsp_fire && port_d && rsp_err;
        d_rdata_d = (rsp_fire && port_d) ? rsp_data : 32'h0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            port_q       <= 1'b0;
            addr_lo_q    <= 2'b00;
            size_q       <= 2'b00;
            signed_q     <= 1'b0;
            wait_cnt_q   <= 16'h0;
            address_q    <= 32'h0;
            writedata_q  <= 32'h0;
            byteenable_q <= 4'b0000;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            f_ready_q    <= 1'b0;
            f_err_q      <= 1'b0;
            f_rdata_q    <= 32'h0;
            d_ready_q    <= 1'b0;
            d_err_q      <= 1'b0;
            d_rdata_q    <= 32'h0;
        end else begin
            state_q      <= state_d;
            port_q       <= port_d;
            addr_lo_q    <= addr_lo_d;
            size_q       <= size_d;
            signed_q     <= signed_d;
            wait_cnt_q   <= wait_cnt_d;
            address_q    <= address_d;
            writedata_q  <= writedata_d;
            byteenable_q <= byteenable_d;
            read_q       <= read_d;
            write_q      <= write_d;
            f_ready_q    <= f_ready_d;
            f_err_q      <= f_err_d;
            f_rdata_q    <= f_rdata_d;
            d_ready_q    <= d_ready_d;
            d_err_q      <= d_err_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    assign bus.address    = address_q;
    assign bus.read       = read_q;
    assign bus.write      = write_q;
    assign bus.writedata  = writedata_q;
    assign bus.byteenable = byteenable_q;
    assign bus.f_ready    = f_ready_q;
    assign bus.f_rdata    = f_rdata_q;
    assign bus.f_err      = f_err_q;
    assign bus.d_ready    = d_ready_q;
    assign bus.d_rdata    = d_rdata_q;
    assign bus.d_err      = d_err_q;
    assign bus.busy       = (state_q != ST_IDLE);
endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Bench for mips_bus_arbiter: transaction-level model checked every cycle,
// plus directed accesses with hand-computed latencies and data.
module tb_mips_bus_arbiter;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    bit   chk_en = 1'b0;
    int   wait_cfg = 0;
    logic [31:0] rd_cfg = 32'h0;

    mips_bus_arbiter_if bus();

    mips_bus_arbiter #(.TIMEOUT(TO), .DATA_FIRST(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    function automatic logic [31:0] m_extract(input logic [31:0] rd, input logic [1:0] lo,
                                              input logic [1:0] sz, input logic sgn);
        int unsigned v, width;
        width = 8 << sz;
        v = rd >> (8 * lo);
        if (width < 32) begin
            v = v % (32'd1 << width);
            if (sgn && v >= (32'd1 << (width - 1))) v = v - (32'd1 << width);
        end
        return v;
    endfunction

    int          m_phase;   // 0 nothing open, 1 bus cycle open, 2 response shown
    int          m_waits;
    logic        m_port, m_we, m_sgn;
    logic [1:0]  m_size, m_lo;
    logic        e_busy, e_read, e_write, e_fr, e_fe, e_dr, e_de;
    logic [31:0] e_addr, e_wd, e_frd, e_drd;
    logic [3:0]  e_be;

    task automatic m_post(input logic err, input logic [31:0] data);
        if (m_port) begin e_dr = 1; e_de = err; e_drd = data; end
        else        begin e_fr = 1; e_fe = err; e_frd = data; end
    endtask

    initial begin
        int bytes;
        logic [31:0] a, wd, pat;
        m_phase = 0;
        forever begin
            @(posedge clk);
            e_fr = 0; e_fe = 0; e_dr = 0; e_de = 0; e_frd = 0; e_drd = 0;
            if (reset) begin
                m_phase = 0; e_read = 0; e_write = 0; e_addr = 0; e_be = 0; e_wd = 0;
            end else begin
                case (m_phase)
                    0: if (bus.f_req || bus.d_req) begin
                        m_port = bus.d_req;
                        a      = m_port ? bus.d_addr : bus.f_addr;
                        m_size = m_port ? bus.d_size : 2'd2;
                        m_sgn  = m_port && bus.d_signed;
                        m_we   = m_port && bus.d_we;
                        wd     = bus.d_wdata;
                        m_lo   = a[1:0];
                        bytes  = 1 << m_size;
                        if (m_size == 2'd3 || (a % bytes) != 0) begin
                            m_post(1'b1, 32'h0);
                            m_phase = 2;
                        end else begin
                            e_read  = !m_we;
                            e_write = m_we;
                            e_addr  = a - (a % 4);
                            e_be    = 4'(((1 << bytes) - 1) << m_lo);
                            pat     = (bytes == 4) ? wd : wd % (32'd1 << (8 * bytes));
                            e_wd    = 0;
                            for (int k = 0; k < 4 / bytes; k++) e_wd = e_wd | (pat << (8 * bytes * k));
                            m_waits = 0;
                            m_phase = 1;
                        end
                    end
                    1: if (!bus.waitrequest) begin
                        e_read = 0; e_write = 0;
                        m_post(1'b0, m_we ? 32'h0 : m_extract(bus.readdata, m_lo, m_size, m_sgn));
                        m_phase = 2;
                    end else begin
                        m_waits++;
                        if (m_waits == TO) begin
                            e_read = 0; e_write = 0;
                            m_post(1'b1, 32'h0);
                            m_phase = 2;
                        end
                    end
                    default: m_phase = 0;
                endcase
            end
            e_busy = (m_phase != 0);
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        logic [6:0] got, want;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                got  = {bus.busy, bus.read, bus.write, bus.f_ready, bus.f_err, bus.d_ready, bus.d_err};
                want = {e_busy, e_read, e_write, e_fr, e_fe, e_dr, e_de};
                total++;
                if (got !== want || bus.f_rdata !== e_frd || bus.d_rdata !== e_drd) begin
                    bad++;
                    $display("FAIL cycle_ctl t=%0t got ctl=%b frd=%h drd=%h, want ctl=%b frd=%h drd=%h",
                             $time, got, bus.f_rdata, bus.d_rdata, want, e_frd, e_drd);
                end
                if (e_read || e_write) begin
                    total++;
                    if (bus.address !== e_addr || bus.byteenable !== e_be ||
                        (e_write && bus.writedata !== e_wd)) begin
                        bad++;
                        $display("FAIL cycle_bus t=%0t got a=%h be=%b wd=%h, want a=%h be=%b wd=%h",
                                 $time, bus.address, bus.byteenable, bus.writedata, e_addr, e_be, e_wd);
                    end
                end
            end
        end
    end

    // ---------------- memory responder ----------------
    initial begin
        int wcnt;
        wcnt = 0;
        bus.waitrequest = 1'b0;
        bus.readdata = 32'h0;
        forever begin
            @(negedge clk);
            if (bus.read || bus.write) begin
                if (wcnt < wait_cfg) begin bus.waitrequest = 1'b1; wcnt++; end
                else bus.waitrequest = 1'b0;
            end else begin
                wcnt = 0;
                bus.waitrequest = 1'b0;
            end
            bus.readdata = rd_cfg;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic data_txn(input logic we, input logic [1:0] sz, input logic sgn,
                            input logic [31:0] addr, input logic [31:0] wd, input int waits,
                            input logic [31:0] rdv, output int lat, output int bus_cyc,
                            output logic [31:0] rdo, output logic erro, output logic [3:0] be_o,
                            output logic [31:0] wd_o, output logic [31:0] addr_o);
        bit done;
        @(negedge clk);
        wait_cfg = waits; rd_cfg = rdv;
        bus.d_req = 1; bus.d_we = we; bus.d_size = sz; bus.d_signed = sgn;
        bus.d_addr = addr; bus.d_wdata = wd;
        lat = 0; bus_cyc = 0; done = 0; rdo = 0; erro = 0; be_o = 0; wd_o = 0; addr_o = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            lat++;
            if (bus.read || bus.write) begin
                bus_cyc++; be_o = bus.byteenable; addr_o = bus.address;
                if (bus.write) wd_o = bus.writedata;
            end
            if (bus.d_ready) begin rdo = bus.d_rdata; erro = bus.d_err; done = 1; end
        end
        check("d_ready_seen", 32'(done), 32'd1);
        bus.d_req = 0;
        wait_cfg = 0;
    endtask

    initial begin
        int lat, bc, flat, dlat;
        logic [31:0] rdo, wdo, ao;
        logic err;
        logic [3:0] beo;
        bit fdone, ddone;

        reset = 1;
        bus.f_req = 0; bus.f_addr = 0;
        bus.d_req = 0; bus.d_we = 0; bus.d_size = 0; bus.d_signed = 0;
        bus.d_addr = 0; bus.d_wdata = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_be", 32'(bus.byteenable), 0);
        check("rst_rdwr", 32'({bus.read, bus.write, bus.d_ready, bus.f_ready}), 0);
        check("model_lh_signed", m_extract(32'h8001_0000, 2'd2, 2'd1, 1'b1), 32'hFFFF_8001);
        chk_en = 1;
        reset = 0;

        // lw 0x1000, no wait
        data_txn(0, 2, 0, 32'h1000, 0, 0, 32'hDEAD_BEEF, lat, bc, rdo, err, beo, wdo, ao);
        check("lw_lat", 32'(lat), 2);
        check("lw_addr", ao, 32'h1000);
        check("lw_be", 32'(beo), 32'hF);
        check("lw_data", rdo, 32'hDEAD_BEEF);

        // sb 0x1003, 3 waits
        data_txn(1, 0, 0, 32'h1003, 32'hAB, 3, 0, lat, bc, rdo, err, beo, wdo, ao);
        check("sb_lat", 32'(lat), 5);
        check("sb_cycles", 32'(bc), 4);
        check("sb_be", 32'(beo), 32'h8);
        check("sb_wd", wdo, 32'hABAB_ABAB);

        // lh at 0x1002, signed / unsigned
        data_txn(0, 1, 1, 32'h1002, 0, 0, 32'h8001_0000, lat, bc, rdo, err, beo, wdo, ao);
        check("lh_s", rdo, 32'hFFFF_8001);
        data_txn(0, 1, 0, 32'h1002, 0, 0, 32'h8001_0000, lat, bc, rdo, err, beo, wdo, ao);
        check("lh_u", rdo, 32'h0000_8001);

        // byte loads and a half store
        data_txn(0, 0, 0, 32'h1001, 0, 1, 32'h1234_5678, lat, bc, rdo, err, beo, wdo, ao);
        check("lbu", rdo, 32'h0000_0056);
        check("lbu_lat", 32'(lat), 3);
        data_txn(0, 0, 1, 32'h1002, 0, 0, 32'h0080_0000, lat, bc, rdo, err, beo, wdo, ao);
        check("lb_s", rdo, 32'hFFFF_FF80);
        data_txn(1, 1, 0, 32'h1002, 32'hFFFF_1234, 0, 0, lat, bc, rdo, err, beo, wdo, ao);
        check("sh_be", 32'(beo), 32'hC);
        check("sh_wd", wdo, 32'h1234_1234);

        // misaligned faults
        data_txn(0, 2, 0, 32'h1002, 0, 0, 32'h5555_5555, lat, bc, rdo, err, beo, wdo, ao);
        check("mis_lw_lat", 32'(lat), 1);
        check("mis_lw_err", 32'(err), 1);
        check("mis_lw_nobus", 32'(bc), 0);
        data_txn(1, 1, 0, 32'h1001, 0, 0, 0, lat, bc, rdo, err, beo, wdo, ao);
        check("mis_sh_err", 32'(err), 1);
        data_txn(0, 3, 0, 32'h1000, 0, 0, 0, lat, bc, rdo, err, beo, wdo, ao);
        check("size3_err", 32'(err), 1);

        // timeout with waitrequest stuck high
        data_txn(0, 2, 0, 32'h2000, 0, 1000, 32'h7777_7777, lat, bc, rdo, err, beo, wdo, ao);
        check("to_cycles", 32'(bc), 4);
        check("to_lat", 32'(lat), 5);
        check("to_err", 32'(err), 1);
        check("to_data", rdo, 0);

        // simultaneous fetch + data: data first, fetch 3 cycles later
        @(negedge clk);
        rd_cfg = 32'h1122_3344;
        bus.f_req = 1; bus.f_addr = 32'h400;
        bus.d_req = 1; bus.d_we = 0; bus.d_size = 2; bus.d_signed = 0; bus.d_addr = 32'h1000;
        flat = 0; dlat = 0; fdone = 0; ddone = 0; rdo = 0;
        for (int c = 1; c < 40 && !fdone; c++) begin
            @(negedge clk);
            if (bus.d_ready && !ddone) begin ddone = 1; dlat = c; bus.d_req = 0; end
            if (bus.f_ready) begin fdone = 1; flat = c; rdo = bus.f_rdata; bus.f_req = 0; end
        end
        check("both_d_lat", 32'(dlat), 2);
        check("both_f_lat", 32'(flat), 5);
        check("both_f_data", rdo, 32'h1122_3344);
        bus.f_req = 0; bus.d_req = 0;

        // misaligned fetch
        @(negedge clk);
        bus.f_req = 1; bus.f_addr = 32'h402;
        @(negedge clk);
        check("mis_fetch_err", 32'({bus.f_ready, bus.f_err}), 32'h3);
        bus.f_req = 0;

        // reset in the middle of a stalled access
        @(negedge clk);
        wait_cfg = 1000;
        bus.d_req = 1; bus.d_we = 0; bus.d_size = 2; bus.d_addr = 32'h3000;
        repeat (2) @(negedge clk);
        check("pre_rst_read", 32'(bus.read), 1);
        reset = 1; bus.d_req = 0;
        @(negedge clk);
        check("rst_mid_read", 32'(bus.read), 0);
        check("rst_mid_busy", 32'(bus.busy), 0);
        check("rst_mid_be", 32'({bus.byteenable, bus.address}), 0);
        reset = 0; wait_cfg = 0;
        @(negedge clk);
        check("rst_mid_noready", 32'({bus.d_ready, bus.f_ready}), 0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
